// File: rtl/gmii_rx_clock_domain_cross_if.sv
// GMII RX byte stream in (PHY side) and framed byte stream out (parser side).
interface gmii_rx_clock_domain_cross_if;
  timeunit 1ns;
  timeprecision 1ps;

  // write domain: raw GMII receive pins
  logic [7:0] rxd;
  logic       rx_dv;
  logic       rx_er;

  // read domain: contiguous frames with end/error marking
  logic [7:0] data;
  logic       data_wr;
  logic       data_last;
  logic       data_err;

  modport master (
    output rxd, rx_dv, rx_er,
    input  data, data_wr, data_last, data_err
  );

  modport slave (
    input  rxd, rx_dv, rx_er,
    output data, data_wr, data_last, data_err
  );
endinterface

// File: rtl/gmii_rx_clock_domain_cross.sv
// GMII RX clock-domain crossing: PHY RX clock -> internal clock through an
// async FIFO of {err,last,data} entries with gray-coded pointers and a
// gray-coded completed-frame counter.
module gmii_rx_clock_domain_cross #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned START_LEVEL = 8
) (
  input  logic                               i_wr_clk,
  input  logic                               i_wr_rst_n,
  input  logic                               i_rd_clk,
  input  logic                               i_rd_rst_n,
  gmii_rx_clock_domain_cross_if.slave        bus,
  output logic                               o_fifo_overflow_pulse,
  output logic                               o_fifo_underrun_pulse
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  // data writes stop one short of full so the end-of-frame entry always fits
  localparam ptr_t FULL_LEVEL  = ptr_t'(DEPTH - 1);
  localparam ptr_t START_FILL  = ptr_t'(START_LEVEL);
  localparam ptr_t PTR_ONE     = ptr_t'(1);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_DISCARD} rd_state_t;

  function automatic ptr_t to_gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t from_gray(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [9:0] mem [DEPTH];

  // ---------------- write domain ----------------
  wr_state_t  wr_state;
  ptr_t       wr_ptr, wr_gray, wr_ptr_next;
  ptr_t       frame_cnt, frame_gray, frame_cnt_next;
  ptr_t       rd_gray_w1, rd_gray_w2, wr_fill;
  logic [7:0] hold;
  logic       err_flag;
  logic       wr_en;
  logic [9:0] wr_word;
  logic       frame_end;
  logic       ovf_hit;

  assign wr_fill        = wr_ptr - from_gray(rd_gray_w2);
  assign wr_ptr_next    = wr_ptr + ptr_t'(wr_en);
  assign frame_cnt_next = frame_cnt + ptr_t'(frame_end);

  // bring the read pointer into the write domain
  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      rd_gray_w1 <= '0;
      rd_gray_w2 <= '0;
    end else begin
      rd_gray_w1 <= rd_gray;
      rd_gray_w2 <= rd_gray_w1;
    end
  end

  // decide what, if anything, goes into the FIFO this write cycle
  always_comb begin
    wr_en     = 1'b0;
    wr_word   = '0;
    frame_end = 1'b0;
    ovf_hit   = 1'b0;
    case (wr_state)
      W_RECV: begin
        if (bus.rx_dv) begin
          if (wr_fill >= FULL_LEVEL) begin
            ovf_hit = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_word = {1'b0, 1'b0, hold};
          end
        end else begin
          wr_en     = 1'b1;
          wr_word   = {err_flag, 1'b1, hold};
          frame_end = 1'b1;
        end
      end
      W_DROP: begin
        if (!bus.rx_dv) begin
          // error marker lands in the slot that data writes never use
          wr_en     = 1'b1;
          wr_word   = {1'b1, 1'b1, 8'h00};
          frame_end = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FIFO storage, written only from the write domain
  always_ff @(posedge i_wr_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
  end

  // write-side frame tracking: one-byte hold so the final byte can be tagged
  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      wr_state              <= W_IDLE;
      wr_ptr                <= '0;
      wr_gray               <= '0;
      frame_cnt             <= '0;
      frame_gray            <= '0;
      hold                  <= '0;
      err_flag              <= 1'b0;
      o_fifo_overflow_pulse <= 1'b0;
    end else begin
      wr_ptr                <= wr_ptr_next;
      wr_gray               <= to_gray(wr_ptr_next);
      frame_cnt             <= frame_cnt_next;
      frame_gray            <= to_gray(frame_cnt_next);
      o_fifo_overflow_pulse <= ovf_hit;
      case (wr_state)
        W_IDLE: begin
          if (bus.rx_dv) begin
            hold     <= bus.rxd;
            err_flag <= bus.rx_er;
            wr_state <= W_RECV;
          end
        end
        W_RECV: begin
          if (bus.rx_dv) begin
            if (ovf_hit) begin
              err_flag <= 1'b0;
              wr_state <= W_DROP;
            end else begin
              hold     <= bus.rxd;
              err_flag <= err_flag | bus.rx_er;
            end
          end else begin
            err_flag <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        W_DROP: begin
          if (!bus.rx_dv) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read domain ----------------
  rd_state_t  rd_state;
  ptr_t       rd_ptr, rd_gray, rd_ptr_inc;
  ptr_t       frames_read;
  ptr_t       wr_gray_r1, wr_gray_r2;
  ptr_t       frame_gray_r1, frame_gray_r2;
  ptr_t       rd_fill;
  logic       rd_empty;
  logic       frame_pending;
  logic [9:0] head;
  logic [7:0] data_q;
  logic       data_wr_q, data_last_q, data_err_q;

  // bring the write pointer and completed-frame count into the read domain
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      wr_gray_r1    <= '0;
      wr_gray_r2    <= '0;
      frame_gray_r1 <= '0;
      frame_gray_r2 <= '0;
    end else begin
      wr_gray_r1    <= wr_gray;
      wr_gray_r2    <= wr_gray_r1;
      frame_gray_r1 <= frame_gray;
      frame_gray_r2 <= frame_gray_r1;
    end
  end

  assign rd_fill       = from_gray(wr_gray_r2) - rd_ptr;
  assign rd_empty      = (rd_fill == '0);
  assign rd_ptr_inc    = rd_ptr + PTR_ONE;
  // the emptiness term guards against the frame count resolving a cycle
  // before the write pointer it was committed with
  assign frame_pending = (from_gray(frame_gray_r2) != frames_read) && !rd_empty;
  assign head          = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // read FSM: wait for enough data or a whole frame, stream it, or discard after underrun
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      rd_state              <= R_IDLE;
      rd_ptr                <= '0;
      rd_gray               <= '0;
      frames_read           <= '0;
      data_q                <= '0;
      data_wr_q             <= 1'b0;
      data_last_q           <= 1'b0;
      data_err_q            <= 1'b0;
      o_fifo_underrun_pulse <= 1'b0;
    end else begin
      data_q                <= '0;
      data_wr_q             <= 1'b0;
      data_last_q           <= 1'b0;
      data_err_q            <= 1'b0;
      o_fifo_underrun_pulse <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if ((rd_fill >= START_FILL) || frame_pending) rd_state <= R_SEND;
        end
        R_SEND: begin
          if (!rd_empty) begin
            rd_ptr      <= rd_ptr_inc;
            rd_gray     <= to_gray(rd_ptr_inc);
            data_q      <= head[7:0];
            data_wr_q   <= 1'b1;
            data_last_q <= head[8];
            data_err_q  <= head[9];
            if (head[8]) begin
              frames_read <= frames_read + PTR_ONE;
              rd_state    <= R_IDLE;
            end
          end else begin
            o_fifo_underrun_pulse <= 1'b1;
            rd_state              <= R_DISCARD;
          end
        end
        R_DISCARD: begin
          if (!rd_empty) begin
            rd_ptr  <= rd_ptr_inc;
            rd_gray <= to_gray(rd_ptr_inc);
            if (head[8]) begin
              frames_read <= frames_read + PTR_ONE;
              rd_state    <= R_IDLE;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.data_wr   = data_wr_q;
  assign bus.data_last = data_last_q;
  assign bus.data_err  = data_err_q;

endmodule
